// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction loader: mnemonic indices, opcodes, field positions.
// No timing or handshake of its own; used by the encoder and the loader FSM.
package imem_loader_pkg;

    localparam logic [3:0] MN_ADD  = 4'd0;
    localparam logic [3:0] MN_SUB  = 4'd1;
    localparam logic [3:0] MN_ADDI = 4'd2;
    localparam logic [3:0] MN_ORI  = 4'd3;
    localparam logic [3:0] MN_AND  = 4'd4;
    localparam logic [3:0] MN_OR   = 4'd5;
    localparam logic [3:0] MN_MOVE = 4'd6;
    localparam logic [3:0] MN_SW   = 4'd7;
    localparam logic [3:0] MN_LW   = 4'd8;
    localparam logic [3:0] MN_BEQ  = 4'd9;
    localparam logic [3:0] MN_HALT = 4'd10;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_OR   = 6'b010010;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int IMM_LSB = 0;

    localparam logic [31:0] HALT_WORD = {OP_HALT, 26'd0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HALT_PAD,
        ST_DONE
    } ld_state_t;

    function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 6] = op;
        w[RS_LSB +: 5] = rs;
        w[RT_LSB +: 5] = rt;
        w[RD_LSB +: 5] = rd;
        return w;
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: 6]   = op;
        w[RS_LSB +: 5]   = rs;
        w[RT_LSB +: 5]   = rt;
        w[IMM_LSB +: 16] = imm;
        return w;
    endfunction

endpackage

// File: rtl/imem_loader_encoder.sv
// Combinational mnemonic-to-word encoder, zero latency, no handshake.
// legal drops for indices 11-15 and the word is then forced to zero.
module insn_encoder
    import imem_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (mnem)
            MN_ADD:  word = r_word(OP_ADD, rs, rt, rd);
            MN_SUB:  word = r_word(OP_SUB, rs, rt, rd);
            MN_AND:  word = r_word(OP_AND, rs, rt, rd);
            MN_OR:   word = r_word(OP_OR, rs, rt, rd);
            // MOVE has no second source; rt is zeroed whatever the input carries
            MN_MOVE: word = r_word(OP_MOVE, rs, 5'd0, rd);
            MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
            MN_ORI:  word = i_word(OP_ORI, rs, rt, imm);
            MN_SW:   word = i_word(OP_SW, rs, rt, imm);
            MN_LW:   word = i_word(OP_LW, rs, rt, imm);
            MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
            MN_HALT: word = HALT_WORD;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Encodes symbolic instructions and writes them to instruction memory while holding the CPU.
// Write strobe 1 cycle after accept; in_ready drops when full or outside LOAD, never on in_valid.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 8,
    parameter bit AUTO_HALT = 1'b1
)(
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 mnem,
    input  logic [4:0]                 rs,
    input  logic [4:0]                 rt,
    input  logic [4:0]                 rd,
    input  logic [15:0]                imm,
    input  logic                       last,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam int               CAP   = DEPTH - int'(AUTO_HALT);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);

    ld_state_t         state, state_nxt;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept, legal_acc, at_cap, end_beat, skip_pad, last_halt;
    logic [CNT_W-1:0]  count_inc;
    logic [ADDR_W-1:0] word_addr;

    insn_encoder u_enc (
        .mnem  (mnem),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .imm   (imm),
        .word  (enc_word),
        .legal (enc_legal)
    );

    assign accept    = in_valid && in_ready;
    assign legal_acc = accept && enc_legal;
    assign count_inc = count + CNT_W'(1);
    assign word_addr = ADDR_W'({count, 2'b00});
    assign at_cap    = legal_acc && (count_inc == CAP_C);
    assign end_beat  = accept && (last || at_cap);
    // A trailing HALT already terminates the program, so no pad is needed
    assign skip_pad  = legal_acc ? (mnem == MN_HALT) : last_halt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (end_beat) begin
                    state_nxt = (AUTO_HALT && !skip_pad) ? ST_HALT_PAD : ST_DONE;
                end
            end
            ST_HALT_PAD: state_nxt = ST_DONE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Release waits out the final strobe so the CPU never fetches a word still being written
    always_comb begin
        in_ready = (state == ST_LOAD) && (count < CAP_C);
        done     = (state == ST_DONE) && !imem_we;
        cpu_hold = !done;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            count      <= '0;
            last_halt  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        count     <= '0;
                        imem_addr <= '0;
                        err       <= 1'b0;
                        last_halt <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (enc_legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_addr;
                            imem_wdata <= enc_word;
                            count      <= count_inc;
                            last_halt  <= (mnem == MN_HALT);
                        end
                        if (!enc_legal || (at_cap && !last)) err <= 1'b1;
                    end
                end
                ST_HALT_PAD: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_addr;
                    imem_wdata <= HALT_WORD;
                    count      <= count_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random load sessions on a 64-word and a 4-word instance,
// each checked against a word-list model built from the encoding and capacity rules.
module tb_imem_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        start64, start4, in_valid, last;
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    logic        ir64, we64, hold64, done64, err64;
    logic [7:0]  addr64;
    logic [31:0] wdata64;
    logic [6:0]  cnt64;
    logic        ir4, we4, hold4, done4, err4;
    logic [7:0]  addr4;
    logic [31:0] wdata4;
    logic [2:0]  cnt4;

    logic        sel4;
    logic [31:0] s_ready, s_we, s_addr, s_wdata, s_hold, s_done, s_err, s_cnt;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t cap64[$];
    wr_t cap4[$];
    wr_t exp_q[$];
    int  exp_cnt, exp_err, exp_acc;

    int  bm[$], brs[$], brt[$], brd[$], bimm[$], bgap[$];
    bit  blast[$], bstart[$];

    imem_loader #(.DEPTH(64), .ADDR_W(8), .AUTO_HALT(1'b1)) dut64 (
        .CLK(CLK), .Reset(Reset), .start(start64), .in_valid(in_valid), .in_ready(ir64),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .last(last),
        .imem_we(we64), .imem_addr(addr64), .imem_wdata(wdata64),
        .cpu_hold(hold64), .done(done64), .err(err64), .count(cnt64)
    );

    imem_loader #(.DEPTH(4), .ADDR_W(8), .AUTO_HALT(1'b1)) dut4 (
        .CLK(CLK), .Reset(Reset), .start(start4), .in_valid(in_valid), .in_ready(ir4),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .last(last),
        .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
        .cpu_hold(hold4), .done(done4), .err(err4), .count(cnt4)
    );

    assign s_ready = sel4 ? 32'(ir4)    : 32'(ir64);
    assign s_we    = sel4 ? 32'(we4)    : 32'(we64);
    assign s_addr  = sel4 ? 32'(addr4)  : 32'(addr64);
    assign s_wdata = sel4 ? wdata4      : wdata64;
    assign s_hold  = sel4 ? 32'(hold4)  : 32'(hold64);
    assign s_done  = sel4 ? 32'(done4)  : 32'(done64);
    assign s_err   = sel4 ? 32'(err4)   : 32'(err64);
    assign s_cnt   = sel4 ? 32'(cnt4)   : 32'(cnt64);

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (we64) cap64.push_back('{int'(addr64), wdata64, cyc});
        if (we4)  cap4.push_back('{int'(addr4), wdata4, cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the opcode table: op*2^26 + rs*2^21 + rt*2^16 + (rd*2^11 | imm)
    function automatic logic [31:0] ref_word(input int m, input int r_s, input int r_t,
                                             input int r_d, input int im);
        logic [31:0] op;
        int          t;
        bit          is_r;
        is_r = 1'b1;
        t    = r_t;
        case (m)
            0: op = 32'd0;
            1: op = 32'd2;
            4: op = 32'd17;
            5: op = 32'd18;
            6: begin op = 32'd32; t = 0; end
            2: begin op = 32'd1;  is_r = 1'b0; end
            3: begin op = 32'd16; is_r = 1'b0; end
            7: begin op = 32'd38; is_r = 1'b0; end
            8: begin op = 32'd39; is_r = 1'b0; end
            9: begin op = 32'd48; is_r = 1'b0; end
            default: return 32'hFC000000;
        endcase
        if (is_r) return op * 32'd67108864 + 32'(r_s) * 32'd2097152 + 32'(t) * 32'd65536 + 32'(r_d) * 32'd2048;
        return op * 32'd67108864 + 32'(r_s) * 32'd2097152 + 32'(t) * 32'd65536 + 32'(im);
    endfunction

    task automatic clear_beats();
        bm.delete(); brs.delete(); brt.delete(); brd.delete(); bimm.delete();
        bgap.delete(); blast.delete(); bstart.delete();
    endtask

    task automatic add_beat(input int m, input int r_s, input int r_t, input int r_d,
                            input int im, input bit l, input int gap, input bit st);
        bm.push_back(m); brs.push_back(r_s); brt.push_back(r_t); brd.push_back(r_d);
        bimm.push_back(im); blast.push_back(l); bgap.push_back(gap); bstart.push_back(st);
    endtask

    // Expected word list: legal beats fill consecutive words, the session ends on last or when
    // only the pad slot remains, and a HALT pad follows unless the final word is already HALT.
    task automatic compute_model(input int depth);
        int  cnt, cap;
        bit  lh, ended;
        wr_t w;
        exp_q.delete();
        exp_err = 0; exp_acc = 0; cnt = 0; lh = 1'b0; ended = 1'b0;
        cap = depth - 1;
        foreach (bm[i]) begin
            if (ended || cnt >= cap) break;
            exp_acc++;
            if (bm[i] <= 10) begin
                w.addr = 4 * cnt;
                w.data = ref_word(bm[i], brs[i], brt[i], brd[i], bimm[i]);
                w.cyc  = 0;
                exp_q.push_back(w);
                cnt++;
                lh = (bm[i] == 10);
            end else begin
                exp_err = 1;
            end
            if (blast[i] || cnt == cap) begin
                if (!blast[i]) exp_err = 1;
                ended = 1'b1;
                if (!lh) begin
                    w.addr = 4 * cnt;
                    w.data = 32'hFC000000;
                    exp_q.push_back(w);
                    cnt++;
                end
            end
        end
        exp_cnt = cnt;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/in_ready"}, s_ready, 0);
        check({tag, "/imem_we"}, s_we, 0);
        check({tag, "/imem_addr"}, s_addr, 0);
        check({tag, "/imem_wdata"}, s_wdata, 0);
        check({tag, "/cpu_hold"}, s_hold, 1);
        check({tag, "/done"}, s_done, 0);
        check({tag, "/err"}, s_err, 0);
        check({tag, "/count"}, s_cnt, 0);
    endtask

    task automatic run_session(input bit use4, input string name);
        int  acc, waited, depth;
        bit  stopped;
        wr_t got[$];
        sel4  = use4;
        depth = use4 ? 4 : 64;
        compute_model(depth);
        cap64.delete();
        cap4.delete();
        @(negedge CLK);
        if (use4) start4 = 1'b1; else start64 = 1'b1;
        @(negedge CLK);
        start4 = 1'b0; start64 = 1'b0;
        check({name, "/hold_in_load"}, s_hold, 1);
        acc = 0; stopped = 1'b0;
        foreach (bm[i]) begin
            if (stopped) break;
            in_valid = 1'b0;
            repeat (bgap[i]) @(negedge CLK);
            mnem = 4'(bm[i]); rs = 5'(brs[i]); rt = 5'(brt[i]); rd = 5'(brd[i]);
            imm = 16'(bimm[i]); last = blast[i]; in_valid = 1'b1;
            if (!use4) start64 = bstart[i];
            waited = 0;
            while (s_ready != 32'd1 && waited < 4) begin
                @(negedge CLK);
                waited++;
            end
            if (s_ready == 32'd1) begin
                @(negedge CLK);
                acc++;
            end else begin
                stopped = 1'b1;
            end
            start64 = 1'b0;
        end
        in_valid = 1'b0; last = 1'b0;
        waited = 0;
        while (s_done != 32'd1 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        got = use4 ? cap4 : cap64;
        check({name, "/done"}, s_done, 1);
        if (!stopped && got.size() > 0)
            check({name, "/done_after_last_strobe"}, cyc, got[got.size()-1].cyc + 1);
        check({name, "/cpu_hold"}, s_hold, 0);
        check({name, "/in_ready_done"}, s_ready, 0);
        check({name, "/accepted"}, acc, exp_acc);
        check({name, "/count"}, s_cnt, exp_cnt);
        check({name, "/err"}, s_err, exp_err);
        check({name, "/nwrites"}, got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            check($sformatf("%s/addr%0d", name, k), got[k].addr, exp_q[k].addr);
            check($sformatf("%s/data%0d", name, k), got[k].data, exp_q[k].data);
        end
    endtask

    initial begin
        int n;
        int m;
        start64 = 1'b0; start4 = 1'b0; in_valid = 1'b0; last = 1'b0;
        mnem = '0; rs = '0; rt = '0; rd = '0; imm = '0; sel4 = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        check_reset("reset64");
        sel4 = 1'b1;
        #1;
        check_reset("reset4");
        Reset = 1'b0;
        sel4 = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle/cpu_hold", s_hold, 1);
        check("idle/in_ready", s_ready, 0);

        clear_beats();
        add_beat(0, 1, 2, 3, 0, 1'b0, 0, 1'b0);
        add_beat(2, 0, 1, 0, 8, 1'b1, 0, 1'b0);
        run_session(1'b0, "add_addi");
        if (cap64.size() == 3) begin
            check("add_addi/w0_lit", cap64[0].data, 32'h00221800);
            check("add_addi/w1_lit", cap64[1].data, 32'h04010008);
            check("add_addi/pad_addr_lit", cap64[2].addr, 8);
        end

        clear_beats();
        add_beat(9, 1, 2, 0, 16'hFFFE, 1'b0, 0, 1'b0);
        add_beat(7, 1, 2, 0, 4, 1'b0, 0, 1'b0);
        add_beat(6, 5, 7, 4, 0, 1'b1, 0, 1'b0);
        run_session(1'b0, "b2b");
        if (cap64.size() == 4) begin
            check("b2b/move_lit", cap64[2].data, 32'h80A02000);
            check("b2b/cyc1", cap64[1].cyc, cap64[0].cyc + 1);
            check("b2b/cyc2", cap64[2].cyc, cap64[1].cyc + 1);
            check("b2b/pad_cyc", cap64[3].cyc, cap64[2].cyc + 1);
        end

        clear_beats();
        add_beat(0, 3, 4, 5, 0, 1'b0, 0, 1'b0);
        add_beat(12, 1, 1, 1, 1, 1'b0, 0, 1'b0);
        add_beat(3, 2, 6, 0, 16'h00F0, 1'b1, 0, 1'b0);
        run_session(1'b0, "illegal");
        if (cap64.size() == 3) check("illegal/next_addr_lit", cap64[1].addr, 4);

        clear_beats();
        add_beat(10, 9, 9, 9, 16'h1234, 1'b1, 0, 1'b0);
        run_session(1'b0, "halt_last");
        check("halt_last/count_lit", s_cnt, 1);

        clear_beats();
        for (int i = 0; i < 5; i++) add_beat(0, i, i + 1, i + 2, 0, 1'b0, 0, 1'b0);
        run_session(1'b1, "capacity");
        check("capacity/err_lit", s_err, 1);

        // Abort a load after two accepted beats
        sel4 = 1'b0;
        @(negedge CLK);
        start64 = 1'b1;
        @(negedge CLK);
        start64 = 1'b0;
        mnem = 4'd0; rs = 5'd1; rt = 5'd1; rd = 5'd1; imm = '0; last = 1'b0; in_valid = 1'b1;
        check("rst_mid/rdy0", s_ready, 1);
        @(negedge CLK);
        mnem = 4'd1;
        check("rst_mid/rdy1", s_ready, 1);
        @(negedge CLK);
        Reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        check("rst_mid/still_held", s_hold, 1);
        clear_beats();
        add_beat(5, 1, 2, 3, 0, 1'b0, 0, 1'b0);
        add_beat(8, 4, 5, 0, 16'h0010, 1'b1, 0, 1'b0);
        run_session(1'b0, "reload");

        for (int s = 0; s < 6; s++) begin
            clear_beats();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                m = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
                add_beat(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 65535), i == n - 1, $urandom_range(0, 2),
                         (i != n - 1) && ($urandom_range(0, 3) == 0));
            end
            run_session(1'b0, $sformatf("rand64_%0d", s));
        end

        for (int s = 0; s < 3; s++) begin
            clear_beats();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                m = ($urandom_range(0, 5) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
                add_beat(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 65535), i == n - 1, $urandom_range(0, 1), 1'b0);
            end
            run_session(1'b1, $sformatf("rand4_%0d", s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
